// File: rtl/firefly_sync_ctrl.sv
// firefly_sync_ctrl: measures the f0 period in clk cycles, averages blocks of
// 2^AVG_LOG2 periods and regenerates a phase-aligned f1 from the average.
// Latency: rise 3 clk after f0 is first sampled high; f1 rises 1 clk after rise.
// Backpressure: none; f0 is a free-running pulse train and is never stalled.
// Build option FIREFLY_DUTY_FOLLOW_EN: f1 copies the measured f0 high time
// instead of running at 50% duty.
module firefly_sync_ctrl #(
  parameter int CNT_W      = 20,
  parameter int MIN_PERIOD = 25000,
  parameter int MAX_PERIOD = 200000,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f0,
  output logic             f1,
  output logic             locked,
  output logic [CNT_W-1:0] period_out,
  output logic             err
);

  localparam int ACC_W = CNT_W + AVG_LOG2;

  localparam logic [CNT_W-1:0]  PCNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  PCNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_P    = CNT_W'(MAX_PERIOD);
  // Sample count value that, with one more valid sample, completes a block.
  localparam logic [AVG_LOG2:0] BLK_LAST = {1'b0, {AVG_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  // Input conditioning
  logic [1:0]       sync_q;
  logic             f0_s_q;
  logic             f0_prev_q;
  logic             rise_q;

  // Measurement and control state
  state_t           state_q,  state_d;
  logic [CNT_W-1:0] pcnt_q,   pcnt_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [AVG_LOG2:0] cnt_q,   cnt_d;
  logic             inv_q,    inv_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             err_q,    err_d;

  // f1 generator
  logic [CNT_W-1:0] ph_q,      ph_d;
  logic [CNT_W-1:0] per_act_q, per_act_d;
  logic [CNT_W-1:0] high_lim;

  logic [ACC_W-1:0] acc_sum;
  logic             sample_ok;
  logic             timeout;

  // Two-flop synchroniser, one retiming stage, then a registered rise detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      f0_s_q    <= 1'b0;
      f0_prev_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], f0};
      f0_s_q    <= sync_q[1];
      f0_prev_q <= f0_s_q;
      rise_q    <= f0_s_q & ~f0_prev_q;
    end
  end

  // Period counter: reload to 1 on every rise, otherwise count and saturate
  always_comb begin
    pcnt_d = pcnt_q;
    if (rise_q) begin
      pcnt_d = PCNT_ONE;
    end else if (pcnt_q != PCNT_MAX) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  // The count at a rise is the sample; a missing rise at MAX_P is a timeout.
  // Checking at MAX_P (not MAX_P+1) lets the state change land on the same
  // edge that takes the counter past MAX_P, and a simultaneous rise wins.
  assign sample_ok = (pcnt_q >= MIN_P) && (pcnt_q <= MAX_P);
  assign timeout   = !rise_q && (pcnt_q >= MAX_P);
  assign acc_sum   = acc_q + ACC_W'(pcnt_q);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pcnt_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      inv_q     <= 1'b0;
      period_q  <= '0;
      err_q     <= 1'b0;
      ph_q      <= '0;
      per_act_q <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      period_q  <= period_d;
      err_q     <= err_d;
      ph_q      <= ph_d;
      per_act_q <= per_act_d;
    end
  end

  // Next state: acquisition, block averaging, rejection and timeout handling
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    period_d = period_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        inv_d = 1'b0;
        // The first rise only opens a measurement window; its count is stale.
        if (rise_q) begin
          state_d = S_ACQ;
        end
      end

      S_ACQ: begin
        if (rise_q) begin
          if (sample_ok) begin
            if (cnt_q == BLK_LAST) begin
              period_d = CNT_W'(acc_sum >> AVG_LOG2);
              acc_d    = '0;
              cnt_d    = '0;
              inv_d    = 1'b0;
              state_d  = S_LOCK;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            err_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_LOCK: begin
        if (rise_q) begin
          if (sample_ok) begin
            inv_d = 1'b0;
            if (cnt_q == BLK_LAST) begin
              period_d = CNT_W'(acc_sum >> AVG_LOG2);
              acc_d    = '0;
              cnt_d    = '0;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Drop the sample and the partial block; a second bad sample in
            // a row means the reference has moved and lock is abandoned.
            err_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
            if (inv_q) begin
              inv_d   = 1'b0;
              state_d = S_ACQ;
            end else begin
              inv_d = 1'b1;
            end
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          inv_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Phase counter: reload on rise, free-run and wrap at the active period.
  // The active period is only refreshed at a reload so f1 never sees a
  // period change mid-cycle.
  always_comb begin
    ph_d      = ph_q;
    per_act_d = per_act_q;
    if (state_q != S_LOCK || rise_q) begin
      ph_d      = '0;
      per_act_d = period_d;
    end else if ((ph_q + 1'b1) >= per_act_q) begin
      ph_d      = '0;
      per_act_d = period_d;
    end else begin
      ph_d = ph_q + 1'b1;
    end
  end

`ifdef FIREFLY_DUTY_FOLLOW_EN
  logic             fall_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] hwidth_q;

  // High-time counter: restart on rise, capture the width on the matching fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall_q   <= 1'b0;
      hcnt_q   <= '0;
      hwidth_q <= '0;
    end else begin
      fall_q <= ~f0_s_q & f0_prev_q;
      if (rise_q) begin
        hcnt_q <= PCNT_ONE;
      end else if (hcnt_q != PCNT_MAX) begin
        hcnt_q <= hcnt_q + 1'b1;
      end
      if (fall_q) begin
        hwidth_q <= hcnt_q;
      end
    end
  end

  // Follow f0 duty, but always leave at least one low cycle per period
  assign high_lim = (hwidth_q < per_act_q) ? hwidth_q : (per_act_q - 1'b1);
`else
  assign high_lim = per_act_q >> 1;
`endif

  // Outputs: lock status and f1 come straight from registered state
  always_comb begin
    locked = 1'b0;
    f1     = 1'b0;
    if (state_q == S_LOCK) begin
      locked = 1'b1;
      f1     = (ph_q < high_lim);
    end
  end

  assign period_out = period_q;
  assign err        = err_q;

endmodule

// File: doc/firefly_sync_ctrl.md
Name: firefly_sync_ctrl

Overview:
- Controller for the firefly divider path. It measures the period of the asynchronous pulse train f0 in clk cycles and averages over a block of periods.
- Once the measurement is stable, it drives f1 at the same frequency, phase-aligned to every f0 rising edge.
- It also reports lock, the current period and errors to the top level. Nominal clk is 50 MHz; f0 runs 0.5–1.2 kHz with arbitrary duty.

Parameters:
- CNT_W, 20, width of period/phase counters (max 1048575 cycles)
- MIN_PERIOD, 25000, shortest accepted f0 period in clk cycles (2 kHz)
- MAX_PERIOD, 200000, longest accepted period / edge timeout (250 Hz)
- AVG_LOG2, 2, log2 of number of periods averaged per update (4)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- f0  in  1  asynchronous input pulse train
- f1  out  1  regenerated, phase-locked output
- locked  out  1  high while a valid averaged period drives f1
- period_out  out  CNT_W  current averaged period in clk cycles
- err  out  1  one-cycle pulse on rejected sample or timeout

Behaviour:
- Reset values: f1=0, locked=0, period_out=0, err=0, state=IDLE, all counters and accumulator 0.
- Reset mid-operation returns to the reset values immediately; it is asynchronous.
- Input conditioning:
  - f0 passes a 2-FF synchroniser, then a registered rising-edge detector (rise).
  - rise is asserted 3 clk after f0 is first sampled high.
- Period counter:
  - pcnt increments every clk; on rise it is reloaded to 1.
  - Sample P = pcnt value at rise, i.e. the clk count between consecutive rises.
  - pcnt saturates at 2^CNT_W-1.
- Valid sample: MIN_PERIOD <= P <= MAX_PERIOD.
- State machine:
  - IDLE: wait for the first rise → ACQ. Sample count and accumulator are cleared.
  - ACQ, on rise with a valid sample: add P to the accumulator (width CNT_W+AVG_LOG2) and increment the sample count.
  - ACQ, on rise with an invalid sample: err=1, clear accumulator and count, stay in ACQ.
  - ACQ, when the count reaches 2^AVG_LOG2: period_out = acc >> AVG_LOG2 (truncating), then → LOCK with locked=1 on the same cycle.
  - LOCK, valid sample: keep accumulating in blocks; each completed block updates period_out.
  - LOCK, invalid sample: err=1, the sample is discarded and the partial block is cleared.
  - LOCK, 2 consecutive invalid samples: → ACQ, locked=0.
  - Any state except IDLE, timeout: pcnt exceeds MAX_PERIOD without a rise → err=1, → IDLE, locked=0, f1=0.
- f1 generator (active only in LOCK):
  - Phase counter ph is reloaded to 0 on rise.
  - Otherwise ph increments and wraps to 0 after period_out-1, so f1 free-runs if an edge is late.
  - f1 = 1 while ph < H; H = period_out >> 1 by default.
  - f1 rises on the cycle after rise.
  - In IDLE and ACQ, f1 = 0.
- Simultaneous rise and timeout in the same cycle: rise wins and no timeout is raised.
- period_out updates take effect at the next ph reload.

Optional Feature:
- Macro: FIREFLY_DUTY_FOLLOW_EN.
- Defined:
  - Add a high-time counter that measures the f0 high width (synchronised rise to fall) of the most recent period.
  - H = that width, clamped to period_out-1; a width of 0 gives f1 = 0.
  - f1 then copies f0 duty.
- Undefined: H = period_out >> 1 (50% duty); the high-time logic is absent.

Test Plan:
- f0 1 kHz, 25% duty (50000/12500 ns-scaled: period 50000 cycles) → locked=1 after 5th rise; period_out=50000; f1 high 25000 cycles, rising 4 clk after each f0 rise.
- f0 periods 40000, 42000, 41000, 43000 → period_out=41500 at 5th rise; then f0 switches to a 100000-cycle period → period_out=100000 after the next 4 valid periods, locked stays 1.
- In LOCK, two consecutive f0 periods of 10000 cycles (5 kHz) → err pulses twice, locked=0, state ACQ, f1=0.
- f0 held low while locked → err pulse and locked=0, f1=0 exactly when pcnt reaches 200001; the next f0 edges re-acquire after 5 rises.
- rst asserted mid-LOCK for 1 cycle → all outputs 0 asynchronously; lock is regained after 5 more valid rises.
- With FIREFLY_DUTY_FOLLOW_EN, period 50000 and f0 high 5000 cycles → f1 high 5000 cycles per period. Without the macro → f1 high 25000.
